// File: rtl/counter_ctrl.sv
// Request sequencer for the lab counter: latches button command pulses as pending
// flags, services one per edge by fixed priority, and owns the RUN-mode timebase.
module counter_ctrl #(
  parameter int WIDTH       = 4,
  parameter int TICK_CYCLES = 125_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  input  logic             toggle_req,
  input  logic             dec_req,
  input  logic             inc_req,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic [4:0]       pending,
  output logic             tick
);

  localparam int             TW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]  TC_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0]  TC_ONE  = TW'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  localparam int P_CLR  = 0;
  localparam int P_TOG  = 1;
  localparam int P_DEC  = 2;
  localparam int P_INC  = 3;
  localparam int P_TICK = 4;

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_RUN    = 1'b1
  } mode_t;

  mode_t            r_mode;
  logic [TW-1:0]    r_tc;
  logic [4:0]       r_pending;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;

  logic [4:0] w_grant;
  logic [4:0] w_req;
  logic [4:0] w_pending_next;
  logic       w_wrap;
  logic       w_stop;
  logic       w_drop_tick;

  // Lowest set bit is the winner: flag order in the vector already encodes priority.
  assign w_grant     = r_pending & (~r_pending + 5'd1);
  assign w_wrap      = (r_mode == S_RUN) && (r_tc == TC_LAST);
  assign w_stop      = w_grant[P_TOG] && (r_mode == S_RUN);
  assign w_drop_tick = w_grant[P_CLR] | w_stop;
  assign w_req       = {1'b0, inc_req, dec_req, toggle_req, clr_req};

  always_comb begin
    w_pending_next = (r_pending & ~w_grant) | w_req;
    if (w_drop_tick) begin
      w_pending_next[P_TICK] = 1'b0;
    end else if (w_wrap) begin
      w_pending_next[P_TICK] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode    <= S_MANUAL;
      r_tc      <= '0;
      r_pending <= '0;
      r_count   <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_tick    <= w_grant[P_TICK];

      if (w_grant[P_CLR]) begin
        r_count <= '0;
      end else if (w_grant[P_DEC]) begin
        r_count <= r_count - CNT_ONE;
      end else if (w_grant[P_INC] || w_grant[P_TICK]) begin
        r_count <= r_count + CNT_ONE;
      end

      if (w_grant[P_TOG]) begin
        r_mode <= (r_mode == S_RUN) ? S_MANUAL : S_RUN;
      end

      // Timebase phase only restarts on clear or a mode change, never on servicing.
      if (w_grant[P_CLR] || w_grant[P_TOG] || (r_mode == S_MANUAL) || w_wrap) begin
        r_tc <= '0;
      end else begin
        r_tc <= r_tc + TC_ONE;
      end
    end
  end

  assign count   = r_count;
  assign running = (r_mode == S_RUN);
  assign pending = r_pending;
  assign tick    = r_tick;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed vector table, hand-written RUN-mode sequences,
// then random requests compared against an event-time reference model.
module tb_counter_ctrl;

  localparam int W    = 4;
  localparam int TICK = 8;
  localparam int MOD  = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr_req = 1'b0;
  logic         toggle_req = 1'b0;
  logic         dec_req = 1'b0;
  logic         inc_req = 1'b0;
  logic [W-1:0] count;
  logic         running;
  logic [4:0]   pending;
  logic         tick;

  int checks = 0;
  int errors = 0;

  counter_ctrl #(.WIDTH(W), .TICK_CYCLES(TICK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .toggle_req (toggle_req),
    .dec_req    (dec_req),
    .inc_req    (inc_req),
    .count      (count),
    .running    (running),
    .pending    (pending),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // Reference model: flags in priority order, count as an integer, and the
  // absolute edge number at which the next tick flag is due.
  int     m_count;
  bit     m_run;
  bit     m_pend[5];
  bit     m_tick;
  longint cyc = 0;
  longint next_tick = 0;

  task automatic model_step(input bit r, input bit [3:0] q);
    int sv;
    bit tick_set;
    sv = -1;
    cyc++;
    if (!r) begin
      m_count = 0;
      m_run   = 0;
      m_tick  = 0;
      for (int p = 0; p < 5; p++) m_pend[p] = 0;
    end else begin
      tick_set = m_run && (cyc == next_tick);
      if (tick_set) next_tick = cyc + TICK;
      for (int p = 0; p < 5; p++) if (sv < 0 && m_pend[p]) sv = p;
      m_tick = (sv == 4);
      if (sv >= 0) m_pend[sv] = 0;
      case (sv)
        0: begin
          m_count = 0;
          next_tick = cyc + TICK;
          tick_set = 0;
          m_pend[4] = 0;
        end
        1: begin
          if (m_run) begin
            m_run = 0;
            tick_set = 0;
            m_pend[4] = 0;
          end else begin
            m_run = 1;
            next_tick = cyc + TICK;
          end
        end
        2: m_count = (m_count + MOD - 1) % MOD;
        3, 4: m_count = (m_count + 1) % MOD;
        default: ;
      endcase
      if (q[3]) m_pend[0] = 1;
      if (q[2]) m_pend[1] = 1;
      if (q[1]) m_pend[2] = 1;
      if (q[0]) m_pend[3] = 1;
      if (tick_set) m_pend[4] = 1;
    end
  endtask

  function automatic logic [4:0] model_pending();
    logic [4:0] v;
    for (int p = 0; p < 5; p++) v[p] = m_pend[p];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One edge: inputs q = {clr, toggle, dec, inc}, held for exactly this edge.
  task automatic cycle(input bit r, input bit [3:0] q);
    rst_n = r;
    {clr_req, toggle_req, dec_req, inc_req} = q;
    @(posedge clk);
    model_step(r, q);
    #1;
  endtask

  typedef struct {
    bit         r;
    bit [3:0]   q;
    logic [3:0] e_count;
    logic       e_run;
    logic [4:0] e_pend;
    logic       e_tick;
  } vec_t;

  function automatic vec_t mk(bit r, bit [3:0] q, logic [3:0] c, logic run,
                              logic [4:0] p, logic t);
    vec_t v;
    v.r = r; v.q = q; v.e_count = c; v.e_run = run; v.e_pend = p; v.e_tick = t;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // Reset with all requests asserted, then wrap, set-wins and priority checks.
    vecs.push_back(mk(0, 4'b1111, 4'd0,  0, 5'b00000, 0));
    vecs.push_back(mk(0, 4'b1111, 4'd0,  0, 5'b00000, 0));
    vecs.push_back(mk(0, 4'b1111, 4'd0,  0, 5'b00000, 0));
    vecs.push_back(mk(1, 4'b0000, 4'd0,  0, 5'b00000, 0));
    vecs.push_back(mk(1, 4'b0010, 4'd0,  0, 5'b00100, 0));
    vecs.push_back(mk(1, 4'b0000, 4'd15, 0, 5'b00000, 0));
    vecs.push_back(mk(1, 4'b0001, 4'd15, 0, 5'b01000, 0));
    vecs.push_back(mk(1, 4'b0000, 4'd0,  0, 5'b00000, 0));
    vecs.push_back(mk(1, 4'b0001, 4'd0,  0, 5'b01000, 0));
    vecs.push_back(mk(1, 4'b0001, 4'd1,  0, 5'b01000, 0));
    vecs.push_back(mk(1, 4'b0001, 4'd2,  0, 5'b01000, 0));
    vecs.push_back(mk(1, 4'b0001, 4'd3,  0, 5'b01000, 0));
    vecs.push_back(mk(1, 4'b0001, 4'd4,  0, 5'b01000, 0));
    vecs.push_back(mk(1, 4'b0000, 4'd5,  0, 5'b00000, 0));
    vecs.push_back(mk(1, 4'b1011, 4'd5,  0, 5'b01101, 0));
    vecs.push_back(mk(1, 4'b0000, 4'd0,  0, 5'b01100, 0));
    vecs.push_back(mk(1, 4'b0000, 4'd15, 0, 5'b01000, 0));
    vecs.push_back(mk(1, 4'b0000, 4'd0,  0, 5'b00000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].r, vecs[i].q);
      $display("vec %0d: rst_n=%0b req=%b -> count=%0d running=%0b pending=%b tick=%0b",
               i, vecs[i].r, vecs[i].q, count, running, pending, tick);
      chk($sformatf("vec%0d count", i),   32'(count),   32'(vecs[i].e_count));
      chk($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].e_run));
      chk($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].e_pend));
      chk($sformatf("vec%0d tick", i),    32'(tick),    32'(vecs[i].e_tick));
    end

    // Auto-count: toggle at edge E (k=0); increments land at E+10, E+18, E+26.
    cycle(1, 4'b0100);
    chk("run k0 running", 32'(running), 32'd0);
    chk("run k0 pending", 32'(pending), 32'b00010);
    cycle(1, 4'b0000);
    chk("run k1 running", 32'(running), 32'd1);
    for (int k = 2; k <= 32; k++) begin
      cycle(1, 4'b0000);
      chk($sformatf("auto k%0d count", k), 32'(count),
          32'((k >= 10) + (k >= 18) + (k >= 26)));
      chk($sformatf("auto k%0d tick", k), 32'(tick),
          32'((k == 10) || (k == 18) || (k == 26)));
    end
    $display("auto-count: count=%0d running=%0b", count, running);

    // Collision: inc pulsed on the edge the tick flag is raised (k=33).
    cycle(1, 4'b0001);
    chk("coll k33 pending", 32'(pending), 32'b11000);
    chk("coll k33 count", 32'(count), 32'd3);
    cycle(1, 4'b0000);
    chk("coll k34 count", 32'(count), 32'd4);
    chk("coll k34 pending", 32'(pending), 32'b10000);
    chk("coll k34 tick", 32'(tick), 32'd0);
    cycle(1, 4'b0000);
    chk("coll k35 count", 32'(count), 32'd5);
    chk("coll k35 tick", 32'(tick), 32'd1);
    chk("coll k35 pending", 32'(pending), 32'b00000);
    for (int k = 36; k <= 48; k++) begin
      cycle(1, 4'b0000);
      if (k == 41) chk("coll k41 pending", 32'(pending), 32'b10000);
      if (k == 42) begin
        chk("coll k42 count", 32'(count), 32'd6);
        chk("coll k42 tick", 32'(tick), 32'd1);
      end
    end
    $display("collision: count=%0d", count);

    // Stop with a tick held behind a dec: tick is dropped, count frozen.
    cycle(1, 4'b0010);
    chk("stop k49 pending", 32'(pending), 32'b10100);
    chk("stop k49 count", 32'(count), 32'd6);
    cycle(1, 4'b0100);
    chk("stop k50 count", 32'(count), 32'd5);
    chk("stop k50 pending", 32'(pending), 32'b10010);
    cycle(1, 4'b0000);
    chk("stop k51 running", 32'(running), 32'd0);
    chk("stop k51 pending", 32'(pending), 32'b00000);
    for (int k = 0; k < 3 * TICK; k++) begin
      cycle(1, 4'b0000);
      chk($sformatf("hold %0d count", k), 32'(count), 32'd5);
      chk($sformatf("hold %0d pending", k), 32'(pending), 32'd0);
      chk($sformatf("hold %0d tick", k), 32'(tick), 32'd0);
    end
    $display("stop: count=%0d running=%0b", count, running);

    // Random requests and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      bit       r;
      bit [3:0] q;
      r    = ($urandom_range(0, 199) != 0);
      q[3] = ($urandom_range(0, 11) == 0);
      q[2] = ($urandom_range(0, 24) == 0);
      q[1] = ($urandom_range(0, 5) == 0);
      q[0] = ($urandom_range(0, 5) == 0);
      cycle(r, q);
      chk($sformatf("rand %0d count", i),   32'(count),   32'(m_count));
      chk($sformatf("rand %0d running", i), 32'(running), 32'(m_run));
      chk($sformatf("rand %0d pending", i), 32'(pending), 32'(model_pending()));
      chk($sformatf("rand %0d tick", i),    32'(tick),    32'(m_tick));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
